qchain_pipe: RTL and testbench

Parametrised pipelined qualifier chain: each lane seeds with the NAND of two inputs, then passes through `STAGES` registered stages. Every inter-stage hop ANDs the lane with a live per-stage qualifier vector, and the final qualifier is applied combinationally at the output. It generalises the fixed 1-bit, 3-stage qualifier chain to `WIDTH` lanes and any depth. It adds valid tracking, stall, flush and an optional hit counter, and sits between the seed-generation logic and the downstream consumer of qualified strobes.

---
 rtl/qchain_pkg.sv | 9 +
 rtl/qchain_stage.sv | 26 ++
 rtl/qchain_pipe.sv | 61 ++++++
 tb/tb_qchain_pipe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/qchain_pkg.sv
// qchain_pkg: shared limits and qualifier slice indexing for qchain_pipe.
package qchain_pkg;
   localparam int QCHAIN_STAGES_MIN = 2;
   localparam int QCHAIN_STAGES_MAX = 16;
   localparam int QCHAIN_CNT_W_DEF = 16;
   function automatic int qual_base(input int k, input int width);
      return k * width;
   endfunction
endpackage

// File: rtl/qchain_stage.sv
// qchain_stage: one registered qualifier stage; invalid items always carry zero data.
module qchain_stage #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_data,
   input  logic [WIDTH-1:0] qual,
   output logic             valid,
   output logic [WIDTH-1:0] data
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (!stall) begin
         valid <= prev_valid;
         data  <= prev_valid ? prev_data & qual : '0;
      end
endmodule

// File: rtl/qchain_pipe.sv
// qchain_pipe: NAND-seeded pipelined qualifier chain with stall/flush.
// Optional saturating hit counter enabled by QCHAIN_HITCNT_EN.
module qchain_pipe import qchain_pkg::*; #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 3,
   parameter int CNT_W  = QCHAIN_CNT_W_DEF
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    STALL,
   input  logic                    FLUSH,
   input  logic                    IN_VALID,
   input  logic [WIDTH-1:0]        SEED_A,
   input  logic [WIDTH-1:0]        SEED_B,
   input  logic [STAGES*WIDTH-1:0] QUAL,
   output logic                    OUT_VALID,
   output logic [WIDTH-1:0]        OUT
`ifdef QCHAIN_HITCNT_EN
   ,output logic [CNT_W-1:0]       HIT_CNT
`endif
);
   logic [WIDTH-1:0] data [STAGES];
   logic             valid [STAGES];

   if (STAGES < QCHAIN_STAGES_MIN || STAGES > QCHAIN_STAGES_MAX || CNT_W < 1) begin : g_bad
      $error("qchain_pipe: illegal STAGES or CNT_W");
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] pd, q;
      logic             pv;
      if (k == 0) begin : g_seed
         assign pd = ~(SEED_A & SEED_B);
         assign pv = IN_VALID;
         assign q  = '1;
      end else begin : g_hop
         assign pd = data[k-1];
         assign pv = valid[k-1];
         assign q  = QUAL[qual_base(k-1, WIDTH) +: WIDTH];
      end
      qchain_stage #(.WIDTH(WIDTH)) u_stage (
         .clk(CLK), .rst_n(RST_N), .stall(STALL), .flush(FLUSH),
         .prev_valid(pv), .prev_data(pd), .qual(q),
         .valid(valid[k]), .data(data[k])
      );
   end

   // Final qualifier is live and combinational to the output.
   assign OUT_VALID = valid[STAGES-1];
   assign OUT = valid[STAGES-1] ? data[STAGES-1] & QUAL[qual_base(STAGES-1, WIDTH) +: WIDTH] : '0;

`ifdef QCHAIN_HITCNT_EN
   logic consume;
   assign consume = OUT_VALID & ~STALL & ~FLUSH;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N)
         HIT_CNT <= '0;
      else if (consume && OUT != '0 && HIT_CNT != '1)
         HIT_CNT <= HIT_CNT + 1'b1;
`endif
endmodule

// File: tb/tb_qchain_pipe.sv
// tb_qchain_pipe: directed checks of qchain_pipe with WIDTH=4, STAGES=3, CNT_W=2.
// Hit-counter checks compile in only with QCHAIN_HITCNT_EN.
module tb_qchain_pipe;
   logic        CLK = 1'b0;
   logic        RST_N, STALL, FLUSH, IN_VALID;
   logic [3:0]  SEED_A, SEED_B;
   logic [11:0] QUAL;
   logic        OUT_VALID;
   logic [3:0]  OUT;
`ifdef QCHAIN_HITCNT_EN
   logic [1:0]  HIT_CNT;
`endif
   int checks = 0;
   int errors = 0;

   qchain_pipe #(.WIDTH(4), .STAGES(3), .CNT_W(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .SEED_A(SEED_A), .SEED_B(SEED_B), .QUAL(QUAL),
      .OUT_VALID(OUT_VALID), .OUT(OUT)
`ifdef QCHAIN_HITCNT_EN
      , .HIT_CNT(HIT_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   logic [3:0] hit_b   [7] = '{4'hF, 4'h3, 4'hF, 4'h3, 4'h3, 4'h3, 4'h3};
   logic [3:0] hit_out [7] = '{4'h0, 4'hC, 4'h0, 4'hC, 4'hC, 4'hC, 4'hC};
   logic [1:0] hit_exp [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      RST_N = 1'b1; STALL = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
      SEED_A = 4'h0; SEED_B = 4'h0; QUAL = 12'hFFF;
      #2 RST_N = 1'b0;
      #1;
      check("reset_ov", OUT_VALID, 0);
      check("reset_out", OUT, 0);
      step(); step();
      RST_N = 1'b1;
      step();
      check("idle_ov", OUT_VALID, 0);

      // latency: accepted at edge t, visible after t+2 for one cycle
      SEED_A = 4'hF; SEED_B = 4'h3; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      check("lat_t0_ov", OUT_VALID, 0);
      step();
      check("lat_t1_ov", OUT_VALID, 0);
      step();
      check("lat_t2_ov", OUT_VALID, 1);
      check("lat_t2_out", OUT, 4'hC);
      step();
      check("lat_t3_ov", OUT_VALID, 0);
      check("lat_t3_out", OUT, 0);

      // qualifier masking on hop 1, then live final qualifier
      QUAL = 12'hF8F; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      step(); step();
      check("mask_ov", OUT_VALID, 1);
      check("mask_out", OUT, 4'h8);
      QUAL = 12'h08F;
      #1;
      check("live_q_ov", OUT_VALID, 1);
      check("live_q_out", OUT, 4'h0);
      QUAL = 12'hFFF;
      step();
      check("mask_drain_ov", OUT_VALID, 0);

      // stall with item in stage 1; inputs during stall are ignored
      SEED_A = 4'hF; SEED_B = 4'h3; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      step();
      STALL = 1'b1; IN_VALID = 1'b1; SEED_A = 4'h0; SEED_B = 4'h0;
      step();
      check("stall1_ov", OUT_VALID, 0);
      step();
      check("stall2_ov", OUT_VALID, 0);
      STALL = 1'b0; IN_VALID = 1'b0;
      step();
      check("stall_arr_ov", OUT_VALID, 1);
      check("stall_arr_out", OUT, 4'hC);
      STALL = 1'b1; QUAL = 12'h4FF;
      #1;
      check("stall_live_out", OUT, 4'h4);
      step();
      check("stall_hold_ov", OUT_VALID, 1);
      check("stall_hold_out", OUT, 4'h4);
      STALL = 1'b0; QUAL = 12'hFFF;
      step();
      check("stall_bubble_ov", OUT_VALID, 0);
      check("stall_bubble_out", OUT, 0);
      step();
      check("stall_nodup_ov", OUT_VALID, 0);

      // flush has priority over stall and drops the same-cycle input
      SEED_A = 4'hF; SEED_B = 4'h3; IN_VALID = 1'b1;
      step(); step(); step();
      check("pre_flush_ov", OUT_VALID, 1);
      FLUSH = 1'b1; STALL = 1'b1;
      step();
      check("flush_ov", OUT_VALID, 0);
      check("flush_out", OUT, 0);
      FLUSH = 1'b0; STALL = 1'b0; IN_VALID = 1'b0;
      step(); step();
      check("flush_drop_ov", OUT_VALID, 0);
      SEED_A = 4'h5; SEED_B = 4'hF; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      step();
      check("post_flush_t1_ov", OUT_VALID, 0);
      step();
      check("post_flush_t2_ov", OUT_VALID, 1);
      check("post_flush_out", OUT, 4'hA);

      // asynchronous reset mid-stream
      SEED_A = 4'hF; SEED_B = 4'h3; IN_VALID = 1'b1;
      step(); step(); step();
      check("pre_rst_ov", OUT_VALID, 1);
      RST_N = 1'b0;
      #1;
      check("async_rst_ov", OUT_VALID, 0);
      check("async_rst_out", OUT, 0);
`ifdef QCHAIN_HITCNT_EN
      check("async_rst_hit", HIT_CNT, 0);
`endif
      IN_VALID = 1'b0;
      step();
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_ov", OUT_VALID, 0);
      end

      // back-to-back items: two zero results and five nonzero
      SEED_A = 4'hF;
      for (int c = 0; c < 10; c++) begin
         IN_VALID = (c < 7);
         SEED_B = (c < 7) ? hit_b[c] : 4'h0;
         step();
         if (c >= 2 && c < 9) begin
            check("stream_ov", OUT_VALID, 1);
            check("stream_out", OUT, hit_out[c-2]);
         end
`ifdef QCHAIN_HITCNT_EN
         if (c >= 3) check("hit_cnt", HIT_CNT, hit_exp[c-3]);
`endif
      end
      check("stream_end_ov", OUT_VALID, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
